// File: rtl/polaris_pkg.sv
// Shared types and constants for the Polaris instruction prefetch unit.
package polaris_pkg;

    localparam logic [1:0] ISIZ_32 = 2'b10;
    localparam logic [1:0] ISIZ_64 = 2'b11;

    localparam logic [63:0] POLARIS_RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00;

    localparam int INST_W = 32;

    typedef struct packed {
        logic [63:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } fetch_state_t;

    function automatic int entry_w(input int addr_w);
        return addr_w + INST_W;
    endfunction

endpackage

// File: rtl/polaris_prefetch_if.sv
// Instruction-bus bundle between the prefetcher (master) and memory (slave).
interface polaris_prefetch_if #(
    parameter int ADDR_W = 64,
    parameter int IBUS_W = 32
);
    logic              icyc;
    logic              istb;
    logic [ADDR_W-1:0] iadr;
    logic [1:0]        isiz;
    logic              iack;
    logic [IBUS_W-1:0] idat;

    modport master (
        output icyc, istb, iadr, isiz,
        input  iack, idat
    );

    modport slave (
        input  icyc, istb, iadr, isiz,
        output iack, idat
    );
endinterface

// File: rtl/polaris_fetch_queue.sv
// Circular {pc, inst} queue with dual in-order push, single pop and flush.
module polaris_fetch_queue
    import polaris_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push0_i,
    input  logic [entry_w(ADDR_W)-1:0] ent0_i,
    input  logic                       push1_i,
    input  logic [entry_w(ADDR_W)-1:0] ent1_i,
    input  logic                       pop_i,
    output logic [entry_w(ADDR_W)-1:0] head_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int EW = entry_w(ADDR_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign do_pop = pop_i && (cnt_q != '0);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            wp_d  = wp_q + PW'(push0_i) + PW'(push1_i);
            rp_d  = rp_q + PW'(do_pop);
            cnt_d = cnt_q + CW'(push0_i) + CW'(push1_i)
                  - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            if (!flush_i && push0_i) mem_q[wp_q] <= ent0_i;
            if (!flush_i && push1_i) mem_q[wp_q + PW'(1)] <= ent1_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    // Gate with valid so an empty queue presents zeros, not stale storage.
    assign head_o  = valid_o ? mem_q[rp_q] : '0;

endmodule

// File: rtl/polaris_prefetch.sv
// Sequential instruction prefetcher: runs ahead on the I bus into a small
// queue, hands one instruction per cycle to the sequencer, flushes on redirect.
module polaris_prefetch
    import polaris_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                IBUS_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(POLARIS_RESET_VEC)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    polaris_prefetch_if.master ibus,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_adr_i,
    output logic               ir_valid_o,
    output logic [31:0]        ir_o,
    output logic [ADDR_W-1:0]  ir_pc_o,
    input  logic               ir_take_i,
    output logic               empty_o
);
    localparam int RSV = (IBUS_W == 64) ? 2 : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EW  = entry_w(ADDR_W);
    localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(IBUS_W / 8 - 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(IBUS_W / 8);
    localparam logic [1:0] ISIZ  = (IBUS_W == 64) ? ISIZ_64 : ISIZ_32;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH - RSV);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] iadr_q, iadr_d;
    logic [1:0]        isiz_q, isiz_d;

    logic [63:0]   dat64;
    logic [31:0]   lo, hi;
    logic          ack, fill, take, launch, credit;
    logic          push0, push1;
    logic [EW-1:0] ent0, ent1;
    logic [CW:0]   occ;

    logic          q_valid, q_full;
    logic [CW-1:0] q_count;
    logic [EW-1:0] q_head;

    assign dat64 = 64'(ibus.idat);
    assign lo    = dat64[31:0];
    assign hi    = (IBUS_W == 64) ? dat64[63:32] : dat64[31:0];

    always_comb begin
        ack   = ibus.iack && (state_q != S_IDLE);
        fill  = ack && (state_q == S_REQ) && !redirect_i;
        take  = ir_take_i && q_valid && !redirect_i;
        push0 = fill && !q_full;
        push1 = push0 && (IBUS_W == 64) && !fpc_q[2];
        // A redirect into the upper half of a 64-bit word keeps only that half.
        ent0  = {fpc_q, ((IBUS_W == 64) && fpc_q[2]) ? hi : lo};
        ent1  = {fpc_q + ADDR_W'(4), hi};

        occ = '0;
        if (!redirect_i) begin
            occ = (CW + 1)'(q_count) + (CW + 1)'(push0)
                + (CW + 1)'(push1) - (CW + 1)'(take);
        end
        credit = (occ <= LIMIT);

        fpc_d = fpc_q;
        if (redirect_i) begin
            fpc_d = redirect_adr_i & ~ADDR_W'(3);
        end else if (fill) begin
            fpc_d = (fpc_q & ~ALIGN) + STEP;
        end

        state_d = state_q;
        iadr_d  = iadr_q;
        isiz_d  = isiz_q;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE: launch = credit;
            S_REQ: begin
                if (ack) launch = credit;
                else if (redirect_i) state_d = S_DISCARD;
            end
            S_DISCARD: launch = ack && credit;
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d = S_REQ;
            iadr_d  = fpc_d & ~ALIGN;
            isiz_d  = ISIZ;
        end else if (ack) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_VEC;
            iadr_q  <= '0;
            isiz_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            iadr_q  <= iadr_d;
            isiz_q  <= isiz_d;
        end
    end

    assign ibus.icyc = (state_q != S_IDLE);
    assign ibus.istb = (state_q != S_IDLE);
    assign ibus.iadr = iadr_q;
    assign ibus.isiz = isiz_q;

    polaris_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (redirect_i),
        .push0_i (push0),
        .ent0_i  (ent0),
        .push1_i (push1),
        .ent1_i  (ent1),
        .pop_i   (take),
        .head_o  (q_head),
        .valid_o (q_valid),
        .full_o  (q_full),
        .count_o (q_count)
    );

    assign ir_valid_o       = q_valid;
    assign {ir_pc_o, ir_o}  = q_head;
    assign empty_o          = !q_valid;

endmodule

// File: tb/tb_polaris_prefetch.sv
// Scenario bench for polaris_prefetch: 32-bit and 64-bit bus instances,
// scoreboard of {pc, inst} checked as the sequencer takes instructions.
module tb_polaris_prefetch;
    import polaris_pkg::*;

    localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ack32 = 1'b0, rd32 = 1'b0, tk32 = 1'b0;
    logic [63:0] ra32 = '0;
    logic        v32, em32;
    logic [31:0] ir32;
    logic [63:0] pc32;

    logic        ack64 = 1'b0, rd64 = 1'b0, tk64 = 1'b0;
    logic [63:0] ra64 = '0;
    logic [63:0] dat64 = '0;
    logic        v64, em64;
    logic [31:0] ir64;
    logic [63:0] pc64;

    int tests = 0;
    int fails = 0;
    logic [95:0] sb[$];

    function automatic logic [31:0] mem32(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    polaris_prefetch_if #(.ADDR_W(64), .IBUS_W(32)) b32 ();
    polaris_prefetch_if #(.ADDR_W(64), .IBUS_W(64)) b64 ();

    assign b32.iack = ack32;
    assign b32.idat = mem32(b32.iadr);
    assign b64.iack = ack64;
    assign b64.idat = dat64;

    polaris_prefetch #(.ADDR_W(64), .IBUS_W(32), .DEPTH(4)) u32 (
        .clk_i(clk), .reset_i(rst), .ibus(b32),
        .redirect_i(rd32), .redirect_adr_i(ra32),
        .ir_valid_o(v32), .ir_o(ir32), .ir_pc_o(pc32),
        .ir_take_i(tk32), .empty_o(em32)
    );

    polaris_prefetch #(.ADDR_W(64), .IBUS_W(64), .DEPTH(4)) u64 (
        .clk_i(clk), .reset_i(rst), .ibus(b64),
        .redirect_i(rd64), .redirect_adr_i(ra64),
        .ir_valid_o(v64), .ir_o(ir64), .ir_pc_o(pc64),
        .ir_take_i(tk64), .empty_o(em64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack32 = 0; rd32 = 0; tk32 = 0;
        ack64 = 0; rd64 = 0; tk64 = 0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        ack32 = 1'b1;
        step();
        tests++; if (b32.istb !== 1'b0) begin fails++;
            $display("FAIL rst_istb got %b exp 0", b32.istb); end
        tests++; if (b32.icyc !== 1'b0) begin fails++;
            $display("FAIL rst_icyc got %b exp 0", b32.icyc); end
        tests++; if (b32.iadr !== 64'h0) begin fails++;
            $display("FAIL rst_iadr got %h exp 0", b32.iadr); end
        tests++; if (b32.isiz !== 2'b00) begin fails++;
            $display("FAIL rst_isiz got %b exp 00", b32.isiz); end
        tests++; if (v32 !== 1'b0) begin fails++;
            $display("FAIL rst_valid got %b exp 0", v32); end
        tests++; if (ir32 !== 32'h0) begin fails++;
            $display("FAIL rst_ir got %h exp 0", ir32); end
        tests++; if (pc32 !== 64'h0) begin fails++;
            $display("FAIL rst_pc got %h exp 0", pc32); end
        tests++; if (em32 !== 1'b1) begin fails++;
            $display("FAIL rst_empty got %b exp 1", em32); end
        tests++; if (b64.icyc !== 1'b0 || em64 !== 1'b1) begin
            fails++; $display("FAIL rst_64 got cyc=%b empty=%b exp 0/1",
                               b64.icyc, em64); end
        ack32 = 1'b0;
    endtask

    task automatic test_stream();
        logic [63:0] epc;
        logic [95:0] e;
        logic a, t;
        sb.delete();
        do_reset();
        rst = 1'b0;
        step();
        tests++; if (b32.istb !== 1'b1 || b32.iadr !== RV) begin fails++;
            $display("FAIL first_req got stb=%b adr=%h exp 1/%h",
                     b32.istb, b32.iadr, RV); end
        ack32 = 1'b1;
        step();
        tests++; if (b32.iadr !== RV + 64'd4) begin fails++;
            $display("FAIL adr_ff04 got %h exp %h", b32.iadr, RV + 64'd4); end
        tests++; if (v32 !== 1'b1 || pc32 !== RV) begin fails++;
            $display("FAIL first_head got v=%b pc=%h exp 1/%h",
                     v32, pc32, RV); end
        step();
        tests++; if (b32.iadr !== RV + 64'd8) begin fails++;
            $display("FAIL adr_ff08 got %h exp %h", b32.iadr, RV + 64'd8); end
        sb.push_back({RV, mem32(RV)});
        sb.push_back({RV + 64'd4, mem32(RV + 64'd4)});
        epc = RV + 64'd8;
        for (int i = 0; i < 240; i++) begin
            tests++; if (v32 !== (sb.size() != 0)) begin fails++;
                $display("FAIL stream_valid got %b exp %b", v32, sb.size() != 0); end
            tests++; if (sb.size() > 4) begin fails++;
                $display("FAIL stream_occ got %0d exp <=4", sb.size()); end
            a = ($urandom_range(3, 0) != 0);
            t = $urandom_range(1, 0) != 0;
            if (t && v32 && sb.size() != 0) begin
                e = sb.pop_front();
                tests++; if ({pc32, ir32} !== e) begin fails++;
                    $display("FAIL stream_head got %h_%h exp %h_%h",
                             pc32, ir32, e[95:32], e[31:0]); end
            end
            if (b32.istb && a) begin
                tests++; if (b32.iadr !== epc) begin fails++;
                    $display("FAIL stream_adr got %h exp %h", b32.iadr, epc); end
                sb.push_back({epc, mem32(epc)});
                epc = epc + 64'd4;
            end
            ack32 = a;
            tk32  = t;
            step();
        end
        ack32 = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            tk32 = 1'b0;
            if (v32) begin
                e = sb.pop_front();
                tests++; if ({pc32, ir32} !== e) begin fails++;
                    $display("FAIL drain_head got %h_%h exp %h_%h",
                             pc32, ir32, e[95:32], e[31:0]); end
                tk32 = 1'b1;
            end
            step();
        end
        tk32 = 1'b0;
        tests++; if (sb.size() != 0 || v32 !== 1'b0) begin fails++;
            $display("FAIL drain_done got left=%0d v=%b exp 0/0", sb.size(), v32); end
    endtask

    task automatic test_full();
        int acks;
        do_reset();
        rst = 1'b0;
        ack32 = 1'b1;
        acks = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            if (b32.istb) acks++;
            step();
        end
        tests++; if (acks != 4) begin fails++;
            $display("FAIL full_pushes got %0d exp 4", acks); end
        tests++; if (b32.istb !== 1'b0) begin fails++;
            $display("FAIL full_stb got %b exp 0", b32.istb); end
        tests++; if (pc32 !== RV) begin fails++;
            $display("FAIL full_head got %h exp %h", pc32, RV); end
        tk32 = 1'b1;
        step();
        tk32 = 1'b0;
        tests++; if (b32.istb !== 1'b1 || b32.iadr !== RV + 64'h10) begin
            fails++; $display("FAIL full_resume got stb=%b adr=%h exp 1/%h",
                               b32.istb, b32.iadr, RV + 64'h10); end
        tests++; if (pc32 !== RV + 64'd4) begin fails++;
            $display("FAIL full_pop got %h exp %h", pc32, RV + 64'd4); end
        ack32 = 1'b0;
    endtask

    task automatic test_redirect_hold();
        do_reset();
        rst = 1'b0;
        step();
        rd32 = 1'b1; ra32 = 64'h2000; ack32 = 1'b1;
        step();
        rd32 = 1'b0;
        tests++; if (v32 !== 1'b0 || b32.iadr !== 64'h2000) begin fails++;
            $display("FAIL rd_ack got v=%b adr=%h exp 0/2000", v32, b32.iadr); end
        step();
        step();
        tests++; if (b32.iadr !== 64'h2008) begin fails++;
            $display("FAIL rd_pre got %h exp 2008", b32.iadr); end
        ack32 = 1'b0; rd32 = 1'b1; ra32 = 64'h1003;
        step();
        rd32 = 1'b0;
        tests++; if (v32 !== 1'b0) begin fails++;
            $display("FAIL rd_flush got %b exp 0", v32); end
        tests++; if (b32.istb !== 1'b1 || b32.iadr !== 64'h2008) begin fails++;
            $display("FAIL rd_hold1 got stb=%b adr=%h exp 1/2008",
                     b32.istb, b32.iadr); end
        step();
        tests++; if (b32.istb !== 1'b1 || b32.iadr !== 64'h2008) begin fails++;
            $display("FAIL rd_hold2 got stb=%b adr=%h exp 1/2008",
                     b32.istb, b32.iadr); end
        ack32 = 1'b1;
        step();
        tests++; if (v32 !== 1'b0) begin fails++;
            $display("FAIL rd_drop got %b exp 0", v32); end
        tests++; if (b32.iadr !== 64'h1000) begin fails++;
            $display("FAIL rd_newadr got %h exp 1000", b32.iadr); end
        step();
        ack32 = 1'b0;
        tests++; if (v32 !== 1'b1 || pc32 !== 64'h1000
                     || ir32 !== mem32(64'h1000)) begin fails++;
            $display("FAIL rd_head got v=%b pc=%h ir=%h exp 1/1000/%h",
                     v32, pc32, ir32, mem32(64'h1000)); end
    endtask

    task automatic test_redirect_take();
        do_reset();
        rst = 1'b0;
        step();
        ack32 = 1'b1;
        step(); step(); step();
        tests++; if (v32 !== 1'b1 || pc32 !== RV) begin fails++;
            $display("FAIL rt_pre got v=%b pc=%h exp 1/%h", v32, pc32, RV); end
        rd32 = 1'b1; ra32 = 64'h3000; tk32 = 1'b1;
        step();
        rd32 = 1'b0; tk32 = 1'b0;
        tests++; if (v32 !== 1'b0 || em32 !== 1'b1) begin fails++;
            $display("FAIL rt_flush got v=%b e=%b exp 0/1", v32, em32); end
        tests++; if (b32.iadr !== 64'h3000) begin fails++;
            $display("FAIL rt_adr got %h exp 3000", b32.iadr); end
        step();
        ack32 = 1'b0;
        tests++; if (v32 !== 1'b1 || pc32 !== 64'h3000
                     || ir32 !== mem32(64'h3000)) begin fails++;
            $display("FAIL rt_head got v=%b pc=%h ir=%h exp 1/3000/%h",
                     v32, pc32, ir32, mem32(64'h3000)); end
    endtask

    task automatic test_bus64();
        logic [95:0] e;
        sb.delete();
        do_reset();
        rst = 1'b0;
        step();
        tests++; if (b64.iadr !== RV || b64.isiz !== 2'b11) begin fails++;
            $display("FAIL b64_first got %h/%b exp %h/11", b64.iadr, b64.isiz, RV); end
        rd64 = 1'b1; ra64 = 64'h1004;
        step();
        rd64 = 1'b0;
        tests++; if (b64.iadr !== RV || b64.istb !== 1'b1) begin fails++;
            $display("FAIL b64_hold got %h/%b exp %h/1", b64.iadr, b64.istb, RV); end
        ack64 = 1'b1; dat64 = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        tests++; if (b64.iadr !== 64'h1000 || v64 !== 1'b0) begin fails++;
            $display("FAIL b64_adr got %h v=%b exp 1000/0", b64.iadr, v64); end
        dat64 = 64'hBBBB_BBBB_AAAA_AAAA;
        step();
        ack64 = 1'b0;
        tests++; if (v64 !== 1'b1 || ir64 !== 32'hBBBB_BBBB
                     || pc64 !== 64'h1004) begin fails++;
            $display("FAIL b64_hi got v=%b ir=%h pc=%h exp 1/bbbbbbbb/1004",
                     v64, ir64, pc64); end
        tests++; if (b64.iadr !== 64'h1008 || b64.isiz !== 2'b11) begin fails++;
            $display("FAIL b64_next got %h/%b exp 1008/11", b64.iadr, b64.isiz); end
        tk64 = 1'b1;
        step();
        tk64 = 1'b0;
        tests++; if (v64 !== 1'b0) begin fails++;
            $display("FAIL b64_single got %b exp 0", v64); end
        dat64 = 64'h2222_2222_1111_1111; ack64 = 1'b1;
        sb.push_back({64'h1008, 32'h1111_1111});
        sb.push_back({64'h100C, 32'h2222_2222});
        step();
        ack64 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            tests++; if (v64 !== 1'b1 || {pc64, ir64} !== e) begin fails++;
                $display("FAIL b64_pair got %b %h_%h exp 1 %h_%h",
                         v64, pc64, ir64, e[95:32], e[31:0]); end
            tk64 = 1'b1;
            step();
        end
        tk64 = 1'b0;
        tests++; if (v64 !== 1'b0) begin fails++;
            $display("FAIL b64_empty got %b exp 0", v64); end
    endtask

    task automatic test_reset_mid();
        ack32 = 1'b0;
        rd32 = 1'b1; ra32 = 64'h4000;
        step();
        rd32 = 1'b0;
        tests++; if (b32.istb !== 1'b1) begin fails++;
            $display("FAIL rm_pre got %b exp 1", b32.istb); end
        rst = 1'b1;
        step();
        tests++; if (b32.istb !== 1'b0 || b32.icyc !== 1'b0) begin fails++;
            $display("FAIL rm_drop got %b/%b exp 0/0", b32.istb, b32.icyc); end
        rst = 1'b0;
        step();
        tests++; if (b32.istb !== 1'b1 || b32.iadr !== RV) begin fails++;
            $display("FAIL rm_restart got %b/%h exp 1/%h", b32.istb, b32.iadr, RV); end
        tests++; if (v32 !== 1'b0 || em32 !== 1'b1) begin fails++;
            $display("FAIL rm_empty got %b/%b exp 0/1", v32, em32); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_hold();
        test_redirect_take();
        test_bus64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
